// File: rtl/shake_mem_streamer.sv
// RAM-to-Keccak streaming adapter: frames a RAM-resident message into command,
// block-header and data words for keccak_top, then returns the squeezed output.
module shake_mem_streamer #(
  parameter int IO_WIDTH  = 32,
  parameter int RAM_DEPTH = 1024,
  localparam int AW       = $clog2(RAM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_mode,
  input  logic [AW-1:0]       i_base_addr,
  input  logic [31:0]         i_input_length,
  input  logic [31:0]         i_output_length,
  output logic                o_busy,
  output logic                o_done,
  output logic [AW-1:0]       o_addr,
  output logic                o_rd_en,
  input  logic [IO_WIDTH-1:0] i_ram_data,
  output logic [IO_WIDTH-1:0] o_core_din,
  output logic                o_core_din_valid,
  input  logic                i_core_din_ready,
  input  logic [IO_WIDTH-1:0] i_core_dout,
  input  logic                i_core_dout_valid,
  output logic                o_core_dout_ready,
  output logic [IO_WIDTH-1:0] o_data_out,
  output logic                o_data_out_valid,
  input  logic                i_data_out_ready
);

  localparam int          NB       = IO_WIDTH / 8;
  localparam int          WSH      = $clog2(IO_WIDTH);
  localparam logic [31:0] RATE_128 = 32'd1344;
  localparam logic [31:0] RATE_256 = 32'd1088;
  localparam logic [31:0] LAST_BIT = 32'h8000_0000;
  localparam logic [31:0] MODE_BIT = 32'h4000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BLK_HDR,
    S_DATA,
    S_OUT
  } state_e;

  function automatic logic [IO_WIDTH-1:0] byte_rev(input logic [IO_WIDTH-1:0] w);
    logic [IO_WIDTH-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = w[8*(NB-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ceil_words(input logic [31:0] bits);
    logic [32:0] t;
    t = {1'b0, bits} + 33'(IO_WIDTH - 1);
    return 32'(t >> WSH);
  endfunction

  state_e              state_q, state_d;
  logic                mode_q;
  logic [31:0]         out_len_q;
  logic [31:0]         rem_q;        // message bits not yet framed into a block
  logic [31:0]         rd_left_q;    // message words not yet requested from RAM
  logic [31:0]         blk_left_q;   // words left to send in the current block
  logic [31:0]         out_left_q;
  logic                last_blk_q;
  logic [AW-1:0]       addr_q;
  logic                rd_pend_q;
  logic [IO_WIDTH-1:0] fifo_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          cnt_q;
  logic                done_q;

  logic [31:0] rate, blk_bits, blk_words, blk_hdr, cmd_word;
  logic        blk_last, start_acc, blk_hs, pop, out_hs, finish, rd_en;
  logic [1:0]  occ;

  assign rate      = mode_q ? RATE_256 : RATE_128;
  assign blk_last  = (rem_q <= rate);
  assign blk_bits  = blk_last ? rem_q : rate;
  assign blk_words = ceil_words(blk_bits);
  assign blk_hdr   = blk_last ? (LAST_BIT | rem_q) : rate;
  assign cmd_word  = (mode_q ? MODE_BIT : 32'h0) + out_len_q;

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d           = state_q;
    o_core_din        = '0;
    o_core_din_valid  = 1'b0;
    o_core_dout_ready = 1'b0;
    o_data_out        = '0;
    o_data_out_valid  = 1'b0;
    start_acc         = 1'b0;
    blk_hs            = 1'b0;
    pop               = 1'b0;
    out_hs            = 1'b0;
    finish            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_acc = i_start;
        if (i_start) state_d = S_HDR;
      end
      S_HDR: begin
        o_core_din       = IO_WIDTH'(cmd_word);
        o_core_din_valid = 1'b1;
        if (i_core_din_ready) state_d = S_BLK_HDR;
      end
      S_BLK_HDR: begin
        o_core_din       = IO_WIDTH'(blk_hdr);
        o_core_din_valid = 1'b1;
        blk_hs           = i_core_din_ready;
        if (blk_hs) state_d = (blk_words == 32'd0) ? S_OUT : S_DATA;
      end
      S_DATA: begin
        o_core_din       = byte_rev(fifo_q[rd_ptr_q]);
        o_core_din_valid = (cnt_q != 2'd0);
        pop              = o_core_din_valid && i_core_din_ready;
        if (pop && blk_left_q == 32'd1) state_d = last_blk_q ? S_OUT : S_BLK_HDR;
      end
      S_OUT: begin
        o_data_out        = byte_rev(i_core_dout);
        o_data_out_valid  = i_core_dout_valid;
        o_core_dout_ready = i_data_out_ready;
        out_hs            = i_core_dout_valid && i_data_out_ready;
        finish            = out_hs && (out_left_q == 32'd1);
        if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy counts the slot freed by a pop this cycle, so reads sustain one
  // word per cycle while the core keeps ready high.
  assign occ   = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign rd_en = (state_q == S_DATA) && (rd_left_q != 32'd0) && (occ < 2'd2);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      out_len_q  <= '0;
      rem_q      <= '0;
      rd_left_q  <= '0;
      blk_left_q <= '0;
      out_left_q <= '0;
      last_blk_q <= 1'b0;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= finish;
      rd_pend_q <= rd_en;
      cnt_q     <= cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
      if (start_acc) begin
        mode_q     <= i_mode;
        out_len_q  <= i_output_length;
        rem_q      <= i_input_length;
        rd_left_q  <= ceil_words(i_input_length);
        out_left_q <= ceil_words(i_output_length);
        addr_q     <= i_base_addr;
      end
      if (blk_hs) begin
        rem_q      <= rem_q - blk_bits;
        blk_left_q <= blk_words;
        last_blk_q <= blk_last;
      end
      if (pop) begin
        blk_left_q <= blk_left_q - 32'd1;
        rd_ptr_q   <= ~rd_ptr_q;
      end
      if (out_hs) out_left_q <= out_left_q - 32'd1;
      if (rd_en) begin
        addr_q    <= (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
        rd_left_q <= rd_left_q - 32'd1;
      end
      if (rd_pend_q) wr_ptr_q <= ~wr_ptr_q;
    end
  end

  // NOTE: the FIFO payload is not reset; the cleared count and pointers make
  // stale contents unreachable, so storage needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (rd_pend_q) fifo_q[wr_ptr_q] <= i_ram_data;
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_addr  = addr_q;
  assign o_rd_en = rd_en;

endmodule
